bram_port_arbiter: RTL and testbench

// Shares the single-port 32-bit BRAM main memory (1-cycle registered read) between two masters.

---
 rtl/bram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter in front of a single-port BRAM with 1-cycle registered read.
// Port A (CPU) has fixed priority. Port B has a starvation guard and an optional
// lock that holds ownership for atomic multi-beat bursts.
module bram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 11,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   // port A (high priority)
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [3:0]            a_wmask,
   input  logic [31:0]           a_wdata,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [31:0]           a_rdata,
   // port B (secondary master)
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [3:0]            b_wmask,
   input  logic [31:0]           b_wdata,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic                  b_lock,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [31:0]           b_rdata,
   // memory side
   output logic                  mem_write,
   output logic [3:0]            mem_wmask,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_rdata
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_BLOCK = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_e;

   state_e           state_q, state_d;
   owner_e           rd_owner_q, rd_owner_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             run_q, run_d;
   logic             a_rvalid_q, a_rvalid_d;
   logic             b_rvalid_q, b_rvalid_d;
   logic             force_b;

   // Grant decision: fixed priority to A, overridden by B lock or B starvation
   always_comb begin
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      force_b = (state_q == ST_ARB) && (wait_cnt_q == CNT_W'(STARVE_LIMIT));
      if (run_q) begin
         if ((state_q == ST_BLOCK) || force_b) begin
            b_gnt = b_req;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req & ~a_req;
         end
      end
   end

   // Memory-side mux: the granted port drives the BRAM, otherwise an idle read of a_addr
   always_comb begin
      mem_write = 1'b0;
      mem_wmask = 4'b0000;
      mem_wdata = 32'h0;
      mem_addr  = a_addr;
      if (a_gnt) begin
         mem_write = a_we;
         mem_wmask = a_wmask;
         mem_wdata = a_wdata;
         mem_addr  = a_addr;
      end else if (b_gnt) begin
         mem_write = b_we;
         mem_wmask = b_wmask;
         mem_wdata = b_wdata;
         mem_addr  = b_addr;
      end
   end

   // Next-state: lock state, starvation counter and read-return ownership
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rd_owner_d = OWN_NONE;
      run_d      = 1'b1;
      a_rvalid_d = a_gnt & ~a_we;
      b_rvalid_d = b_gnt & ~b_we;

      case (state_q)
         ST_ARB:   if (b_gnt && b_lock) state_d = ST_BLOCK;
         ST_BLOCK: if (!b_req || !b_lock) state_d = ST_ARB;
         default:  state_d = ST_ARB;
      endcase

      if (!b_req || b_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q < CNT_W'(STARVE_LIMIT)) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end

      if (a_rvalid_d) begin
         rd_owner_d = OWN_A;
      end else if (b_rvalid_d) begin
         rd_owner_d = OWN_B;
      end
   end

   // State registers; reset abandons any lock and drops pending read returns
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_ARB;
         wait_cnt_q <= '0;
         rd_owner_q <= OWN_NONE;
         run_q      <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_owner_q <= rd_owner_d;
         run_q      <= run_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
      end
   end

   // Read data is steered by the registered owner, never by the current grant
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = (rd_owner_q == OWN_A) ? mem_rdata : 32'h0;
   assign b_rdata  = (rd_owner_q == OWN_B) ? mem_rdata : 32'h0;

   // Grants are mutually exclusive
   a_b_gnt_exclusive : assert property (@(posedge clk) disable iff (!rstn) !(a_gnt && b_gnt));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, reference arbiter model, directed and random stimulus.
module tb_bram_port_arbiter;

   localparam int unsigned AW  = 11;
   localparam int unsigned LIM = 8;
   localparam int unsigned NW  = 2048;

   logic          clk = 1'b0;
   logic          rstn;
   logic          a_req, a_we, a_gnt, a_rvalid;
   logic [3:0]    a_wmask;
   logic [31:0]   a_wdata, a_rdata;
   logic [AW-1:0] a_addr;
   logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
   logic [3:0]    b_wmask;
   logic [31:0]   b_wdata, b_rdata;
   logic [AW-1:0] b_addr;
   logic          mem_write;
   logic [3:0]    mem_wmask;
   logic [31:0]   mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   int checks   = 0;
   int failures = 0;

   bram_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rstn(rstn),
      .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
      .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port BRAM with 1-cycle registered read and byte mask
   logic [31:0] bram [NW];
   always @(posedge clk) begin
      if (mem_write) begin
         for (int i = 0; i < 4; i++)
            if (mem_wmask[i]) bram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      mem_rdata <= bram[mem_addr];
   end

   // Reference model state
   logic [31:0] ref_mem [NW];
   bit          m_started, m_locked, m_arv, m_brv;
   int          m_starve;
   logic [31:0] m_adata, m_bdata;
   bit          exp_a_gnt, exp_b_gnt;

   // Last sampled DUT outputs, used by driver and literal checks
   bit          obs_a_gnt, obs_b_gnt, obs_a_rv, obs_b_rv;
   logic [31:0] obs_a_rdata, obs_b_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_started = 0; m_locked = 0; m_starve = 0; m_arv = 0; m_brv = 0;
   endtask

   // Who should own the memory this cycle, from the current requests
   task automatic model_comb();
      exp_a_gnt = 0;
      exp_b_gnt = 0;
      if (m_started) begin
         if (m_locked || m_starve >= int'(LIM)) begin
            exp_b_gnt = b_req;
         end else begin
            exp_a_gnt = a_req;
            exp_b_gnt = b_req && !a_req;
         end
      end
   endtask

   // Effects of this cycle's grant, applied at the clock edge
   task automatic model_update();
      if (exp_a_gnt && a_we) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wmask);
      if (exp_b_gnt && b_we) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_wmask);
      m_arv = exp_a_gnt && !a_we;
      m_brv = exp_b_gnt && !b_we;
      if (m_arv) m_adata = ref_mem[a_addr];
      if (m_brv) m_bdata = ref_mem[b_addr];
      m_locked = exp_b_gnt && b_lock;
      if (b_req && !exp_b_gnt) m_starve = (m_starve + 1 > int'(LIM)) ? int'(LIM) : m_starve + 1;
      else m_starve = 0;
      m_started = 1;
   endtask

   // One clock cycle: entered at negedge with inputs set, returns at the next negedge
   task automatic cycle();
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_mask;
      logic        e_wr;
      #1;
      model_comb();
      chk("a_gnt", 32'(a_gnt), 32'(exp_a_gnt));
      chk("b_gnt", 32'(b_gnt), 32'(exp_b_gnt));
      chk("gnt_exclusive", 32'(a_gnt & b_gnt), 32'd0);
      e_wr = 0; e_mask = 4'b0; e_wd = 32'h0; e_addr = 32'(a_addr);
      if (exp_a_gnt) begin
         e_wr = a_we; e_mask = a_wmask; e_wd = a_wdata; e_addr = 32'(a_addr);
      end else if (exp_b_gnt) begin
         e_wr = b_we; e_mask = b_wmask; e_wd = b_wdata; e_addr = 32'(b_addr);
      end
      chk("mem_write", 32'(mem_write), 32'(e_wr));
      chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
      chk("mem_wdata", mem_wdata, e_wd);
      chk("mem_addr", 32'(mem_addr), e_addr);
      chk("a_rvalid", 32'(a_rvalid), 32'(m_arv));
      chk("b_rvalid", 32'(b_rvalid), 32'(m_brv));
      if (m_arv) chk("a_rdata", a_rdata, m_adata);
      if (m_brv) chk("b_rdata", b_rdata, m_bdata);
      obs_a_gnt = a_gnt; obs_b_gnt = b_gnt;
      obs_a_rv = a_rvalid; obs_b_rv = b_rvalid;
      obs_a_rdata = a_rdata; obs_b_rdata = b_rdata;
      @(posedge clk);
      if (rstn) model_update();
      @(negedge clk);
   endtask

   bit          t2_ag [18], t2_bg [18], t2_arv [18], t2_brv [18];
   logic [31:0] t2_ard [18], t2_brd [18];
   bit          found;

   initial begin
      for (int i = 0; i < int'(NW); i++) begin
         bram[i]    = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
         ref_mem[i] = bram[i];
      end
      bram[11'h010] = 32'hDEAD_BEEF; ref_mem[11'h010] = 32'hDEAD_BEEF;
      bram[11'h004] = 32'hA0A0_0004; ref_mem[11'h004] = 32'hA0A0_0004;
      bram[11'h008] = 32'hB0B0_0008; ref_mem[11'h008] = 32'hB0B0_0008;
      bram[11'h020] = 32'h1122_3344; ref_mem[11'h020] = 32'h1122_3344;

      rstn = 0;
      a_req = 0; a_we = 0; a_wmask = 0; a_wdata = 0; a_addr = 0;
      b_req = 0; b_we = 0; b_wmask = 0; b_wdata = 0; b_addr = 0; b_lock = 0;
      model_reset();
      @(negedge clk);
      a_req = 1; b_req = 1;
      #1;
      chk("reset_a_gnt", 32'(a_gnt), 32'd0);
      chk("reset_b_gnt", 32'(b_gnt), 32'd0);
      chk("reset_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("reset_b_rvalid", 32'(b_rvalid), 32'd0);
      a_req = 0; b_req = 0;
      @(negedge clk);
      rstn = 1;
      cycle();

      // Lone A read
      a_req = 1; a_we = 0; a_addr = 11'h010;
      cycle();
      chk("t1_a_gnt", 32'(obs_a_gnt), 32'd1);
      a_req = 0;
      cycle();
      chk("t1_a_rvalid", 32'(obs_a_rv), 32'd1);
      chk("t1_a_rdata", obs_a_rdata, 32'hDEAD_BEEF);
      chk("t1_b_rvalid", 32'(obs_b_rv), 32'd0);

      // Both requesting: starvation guard, then distinct read data per port
      cycle();
      a_req = 1; a_we = 0; a_addr = 11'h004;
      b_req = 1; b_we = 0; b_addr = 11'h008; b_lock = 0;
      for (int i = 0; i < 18; i++) begin
         cycle();
         t2_ag[i] = obs_a_gnt; t2_bg[i] = obs_b_gnt;
         t2_arv[i] = obs_a_rv; t2_brv[i] = obs_b_rv;
         t2_ard[i] = obs_a_rdata; t2_brd[i] = obs_b_rdata;
      end
      chk("t2_b_denied_8th", 32'(t2_bg[7]), 32'd0);
      chk("t2_b_forced_9th", 32'(t2_bg[8]), 32'd1);
      chk("t2_a_blocked_9th", 32'(t2_ag[8]), 32'd0);
      chk("t2_a_back_10th", 32'(t2_ag[9]), 32'd1);
      chk("t2_b_forced_18th", 32'(t2_bg[17]), 32'd1);
      chk("t3_a_rvalid", 32'(t2_arv[8]), 32'd1);
      chk("t3_a_rdata", t2_ard[8], 32'hA0A0_0004);
      chk("t3_b_rvalid", 32'(t2_brv[9]), 32'd1);
      chk("t3_b_rdata", t2_brd[9], 32'hB0B0_0008);

      // Locked B burst of four writes while A keeps requesting
      b_we = 1; b_lock = 1; b_wmask = 4'hF; b_addr = 11'h100; b_wdata = 32'hC000_0100;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = obs_b_gnt;
      end
      chk("t4_first_beat", 32'(found), 32'd1);
      for (int k = 1; k < 4; k++) begin
         b_addr = AW'(11'h100 + k); b_wdata = 32'hC000_0100 + 32'(k);
         cycle();
         chk("t4_b_beat", 32'(obs_b_gnt), 32'd1);
         chk("t4_a_held", 32'(obs_a_gnt), 32'd0);
      end
      b_req = 0;
      cycle();
      cycle();
      chk("t4_a_after_lock", 32'(obs_a_gnt), 32'd1);
      a_req = 0;

      // Byte-masked write then read-back
      b_lock = 0; b_req = 1; b_we = 1; b_addr = 11'h020; b_wmask = 4'b0010; b_wdata = 32'h0000_AB00;
      cycle();
      chk("t5_write_gnt", 32'(obs_b_gnt), 32'd1);
      b_we = 0;
      cycle();
      b_req = 0;
      cycle();
      chk("t5_rvalid", 32'(obs_b_rv), 32'd1);
      chk("t5_rdata", obs_b_rdata, 32'h1122_AB44);

      // Reset during a locked burst with a read return pending
      a_req = 1; a_we = 0; a_addr = 11'h010;
      b_req = 1; b_we = 0; b_addr = 11'h030; b_lock = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         found = obs_b_gnt;
      end
      chk("t6_locked", 32'(found), 32'd1);
      chk("t6_pending_rvalid", 32'(b_rvalid), 32'd1);
      rstn = 0;
      #1;
      chk("t6_a_rvalid_cleared", 32'(a_rvalid), 32'd0);
      chk("t6_b_rvalid_cleared", 32'(b_rvalid), 32'd0);
      chk("t6_no_gnt_in_reset", 32'(a_gnt | b_gnt), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1;
      cycle();
      chk("t6_no_gnt_first", 32'(obs_a_gnt | obs_b_gnt), 32'd0);
      cycle();
      chk("t6_a_first", 32'(obs_a_gnt), 32'd1);
      chk("t6_b_not_first", 32'(obs_b_gnt), 32'd0);

      // Random traffic; requests hold stable until granted, sometimes withdrawn
      a_req = 0; b_req = 0; b_lock = 0;
      cycle();
      for (int n = 0; n < 3000; n++) begin
         if (!a_req || obs_a_gnt) begin
            a_req   = ($urandom_range(0, 9) < 5);
            a_we    = ($urandom_range(0, 2) == 0);
            a_wmask = 4'($urandom);
            a_wdata = $urandom;
            a_addr  = AW'(11'h040 + $urandom_range(0, 15));
         end else if ($urandom_range(0, 15) == 0) begin
            a_req = 0;
         end
         if (!b_req || obs_b_gnt) begin
            b_req   = (b_lock && obs_b_gnt) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 6);
            b_we    = ($urandom_range(0, 1) == 0);
            b_wmask = 4'($urandom);
            b_wdata = $urandom;
            b_addr  = AW'(11'h040 + $urandom_range(0, 15));
            b_lock  = ($urandom_range(0, 9) < 3);
         end else if ($urandom_range(0, 15) == 0) begin
            b_req = 0;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
